mod_pow_ctrl: RTL and testbench

//  Sequencer computing result = base^exp mod m by right-to-left square-and-multiply.

---
 rtl/mod_pow_ctrl.sv | 143 ++++++++++++++
 tb/tb_mod_pow_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_pow_ctrl.sv
// Modular exponentiation sequencer: right-to-left square-and-multiply
// driving one external a*b mod m unit through a start/done handshake.
module mod_pow_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_exp,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_mm_start,
  output logic [WIDTH-1:0] o_mm_a,
  output logic [WIDTH-1:0] o_mm_b,
  output logic [WIDTH-1:0] o_mm_m,
  input  logic [WIDTH-1:0] i_mm_result,
  input  logic             i_mm_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_REDUCE,
    S_CHECK,
    S_MUL,
    S_WBUSY,
    S_WDONE,
    S_MUL_WB,
    S_SQR,
    S_SQR_WB,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           r_ret;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_mm_start;
  logic [WIDTH-1:0] r_mm_a;
  logic [WIDTH-1:0] r_mm_b;
  logic [WIDTH-1:0] r_mm_m;
  logic             w_last_bit;

  assign o_result   = r_result;
  assign o_done     = r_done;
  assign o_mm_start = r_mm_start;
  assign o_mm_a     = r_mm_a;
  assign o_mm_b     = r_mm_b;
  assign o_mm_m     = r_mm_m;

  // final exponent bit needs no trailing square
  assign w_last_bit = (r_e == WIDTH'(1));

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_LOAD;
      S_LOAD:   w_next = (i_m == '0) ? S_FIN : S_REDUCE;
      S_REDUCE: if (r_x < r_mm_m) w_next = S_CHECK;
      S_CHECK: begin
        if (r_e == '0)  w_next = S_FIN;
        else if (r_e[0]) w_next = S_MUL;
        else             w_next = S_SQR;
      end
      S_MUL:    w_next = S_WBUSY;
      S_WBUSY:  if (!i_mm_done) w_next = S_WDONE;
      S_WDONE:  if (i_mm_done) w_next = r_ret;
      S_MUL_WB: w_next = S_SQR;
      S_SQR:    w_next = w_last_bit ? S_SHIFT : S_WBUSY;
      S_SQR_WB: w_next = S_SHIFT;
      S_SHIFT:  w_next = S_CHECK;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // datapath: operands, accumulator and modmul launch
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ret      <= S_IDLE;
      r_r        <= '0;
      r_x        <= '0;
      r_e        <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_mm_m     <= '0;
    end else begin
      r_mm_start <= 1'b0;
      case (r_state)
        S_IDLE: r_done <= ~i_start;
        S_LOAD: begin
          r_x    <= i_base;
          r_e    <= i_exp;
          r_mm_m <= i_m;
          r_r    <= (i_m > WIDTH'(1)) ? WIDTH'(1) : '0;
        end
        S_REDUCE: begin
          if (r_x >= r_mm_m) r_x <= r_x - r_mm_m;
        end
        S_MUL: begin
          r_mm_a     <= r_r;
          r_mm_b     <= r_x;
          r_mm_start <= 1'b1;
          r_ret      <= S_MUL_WB;
        end
        S_MUL_WB: r_r <= i_mm_result;
        S_SQR: begin
          if (!w_last_bit) begin
            r_mm_a     <= r_x;
            r_mm_b     <= r_x;
            r_mm_start <= 1'b1;
            r_ret      <= S_SQR_WB;
          end
        end
        S_SQR_WB: r_x <= i_mm_result;
        S_SHIFT:  r_e <= r_e >> 1;
        S_FIN: begin
          r_result <= r_r;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_pow_ctrl.sv
// Randomized bench for mod_pow_ctrl with a behavioural modmul
// and a plain-arithmetic exponentiation reference.
module tb_mod_pow_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] b_in = '0;
  logic [W-1:0] e_in = '0;
  logic [W-1:0] m_in = '0;
  logic [W-1:0] result;
  logic         done;
  logic         mm_start;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_m;
  logic [W-1:0] mm_res = '0;
  logic         mm_done = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  bit           mm_busy = 1'b0;
  int           mm_cnt = 0;
  int           pulses = 0;
  logic [W-1:0] cap_a = '0;
  logic [W-1:0] cap_b = '0;
  logic [W-1:0] cap_m = '0;
  bit           exp_valid = 1'b0;
  logic [W-1:0] exp_result = '0;

  always #5 clk = ~clk;

  mod_pow_ctrl #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_base      (b_in),
    .i_exp       (e_in),
    .i_m         (m_in),
    .o_result    (result),
    .o_done      (done),
    .o_mm_start  (mm_start),
    .o_mm_a      (mm_a),
    .o_mm_b      (mm_b),
    .o_mm_m      (mm_m),
    .i_mm_result (mm_res),
    .i_mm_done   (mm_done)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // reference: base^exp mod m, plus number of modmul ops issued
  function automatic void model(input longint unsigned b,
                                input longint unsigned e,
                                input longint unsigned m,
                                output longint unsigned r,
                                output int p);
    longint unsigned x;
    p = 0;
    if (m == 0) begin
      r = 0;
      return;
    end
    r = 1 % m;
    x = b % m;
    while (e != 0) begin
      if (e[0]) begin
        r = (r * x) % m;
        p++;
      end
      e = e >> 1;
      if (e != 0) begin
        x = (x * x) % m;
        p++;
      end
    end
  endfunction

  // modmul with random latency; checks operand rules
  always @(negedge clk) begin
    if (rst) begin
      mm_busy = 1'b0;
      mm_done = 1'b1;
      mm_cnt  = 0;
    end else if (mm_busy) begin
      chk("mm_a_stable", mm_a, cap_a);
      chk("mm_b_stable", mm_b, cap_b);
      chk("mm_m_stable", mm_m, cap_m);
      chk("mm_one_pulse", mm_start, 0);
      mm_cnt--;
      if (mm_cnt == 0) begin
        if (cap_m != 0)
          mm_res = W'((longint'(cap_a) * longint'(cap_b))
                      % longint'(cap_m));
        mm_done = 1'b1;
        mm_busy = 1'b0;
      end
    end else if (mm_start) begin
      pulses++;
      cap_a = mm_a;
      cap_b = mm_b;
      cap_m = mm_m;
      chk("mm_a_lt_m", mm_a < mm_m, 1);
      chk("mm_b_lt_m", mm_b < mm_m, 1);
      mm_done = 1'b0;
      mm_cnt  = $urandom_range(1, 40);
      mm_busy = 1'b1;
    end
  end

  // per-cycle output checks
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_valid && done) chk("idle_result", result, exp_result);
      if (mm_busy) chk("busy_not_done", done, 0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("idle_timeout", done, 1);
  endtask

  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] m, input bit poke,
                        output logic [W-1:0] got);
    longint unsigned r;
    int p;
    int n;
    model(b, e, m, r, p);
    wait_idle();
    exp_valid  = 1'b0;
    exp_result = W'(r);
    pulses     = 0;
    b_in  = b;
    e_in  = e;
    m_in  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_drop", done, 0);
    @(negedge clk);
    if (poke && p > 0) begin
      n = 0;
      while (!mm_busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      start = 1'b1;
      b_in  = $urandom;
      e_in  = $urandom;
      m_in  = $urandom & 32'h7FFF_FFFF;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    got = result;
    chk("op_result", result, r);
    chk("op_pulses", pulses, p);
    exp_valid = 1'b1;
  endtask

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] mm;
    logic [W-1:0] bb;
    logic [W-1:0] ee;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mm_start", mm_start, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    chk("rst_mm_m", mm_m, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("done_after_rst", done, 1);

    run_op(3, 5, 7, 1'b1, got);
    chk("lit_3^5%7", got, 5);
    run_op(2, 10, 1000, 1'b0, got);
    chk("lit_2^10%1000", got, 24);
    run_op(9, 0, 7, 1'b0, got);
    chk("lit_9^0%7", got, 1);
    chk("lit_exp0_pulses", pulses, 0);
    run_op(4, 3, 1, 1'b0, got);
    chk("lit_m1", got, 0);
    run_op(20, 2, 7, 1'b0, got);
    chk("lit_20^2%7", got, 1);
    run_op(6, 3, 0, 1'b0, got);
    chk("lit_m0", got, 0);
    chk("lit_m0_pulses", pulses, 0);

    // abort a long operation while a multiply is outstanding
    wait_idle();
    exp_valid = 1'b0;
    b_in  = 3;
    e_in  = 32'hFFFF;
    m_in  = 1000003;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!mm_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_mm_busy", mm_busy, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mm_start", mm_start, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(5, 3, 13, 1'b1, got);
    chk("lit_5^3%13", got, 8);

    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 5))
        0:       mm = $urandom_range(0, 3);
        1, 2:    mm = $urandom_range(2, 1000);
        default: mm = $urandom & 32'h7FFF_FFFF;
      endcase
      bb = W'(longint'($urandom) % (longint'(mm) * 2 + 5));
      case ($urandom_range(0, 3))
        0:       ee = $urandom_range(0, 15);
        3:       ee = $urandom;
        default: ee = $urandom & 32'hFFFF;
      endcase
      run_op(bb, ee, mm, ($urandom % 2) == 1, got);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
